// File: rtl/pwm_gen3.sv
// rtl/pwm_gen3.sv - three-phase centre-aligned PWM with complementary gates and dead time
// Up/down carrier, period-synchronous duty shadowing, per-phase dead-time insertion.
module pwm_gen3 #(
    parameter logic [15:0] PERIOD    = 16'd1024,
    parameter logic [7:0]  DEAD_TIME = 8'd20
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        en,
    input  logic        duty_valid,
    input  logic [15:0] duty_a,
    input  logic [15:0] duty_b,
    input  logic [15:0] duty_c,
    output logic        pwm_ah,
    output logic        pwm_al,
    output logic        pwm_bh,
    output logic        pwm_bl,
    output logic        pwm_ch,
    output logic        pwm_cl,
    output logic        zero_pulse,
    output logic        top_pulse
);

    logic [15:0]      cnt_q, cnt_d;
    logic             up_q, up_d;
    logic [2:0][15:0] pend_q, pend_d;
    logic [2:0][15:0] act_q, act_d;
    logic [2:0]       raw;
    logic [2:0]       raw_q, raw_d;
    logic [2:0][7:0]  dt_q, dt_d;
    logic [2:0]       gh_q, gh_d;
    logic [2:0]       gl_q, gl_d;
    logic             zero_q, zero_d;
    logic             top_q, top_d;

    always_comb begin
        cnt_d = cnt_q;
        up_d  = up_q;
        if (!en) begin
            cnt_d = '0;
            up_d  = 1'b1;
        end else if (up_q) begin
            if (cnt_q == PERIOD) begin
                cnt_d = PERIOD - 16'd1;
                up_d  = 1'b0;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end else begin
            if (cnt_q == 16'd1) begin
                cnt_d = '0;
                up_d  = 1'b1;
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
        end
    end

    // Active duties only move at the period start, so a pulse is never split.
    always_comb begin
        pend_d = pend_q;
        act_d  = act_q;
        if (duty_valid) begin
            pend_d = {duty_c, duty_b, duty_a};
        end
        if (en && (cnt_q == 16'd0)) begin
            act_d = pend_q;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            raw[i] = (cnt_q < act_q[i]);
        end
    end

    // Gap counts down to 1 then releases; the gate drop and the gap together span DEAD_TIME cycles.
    always_comb begin
        raw_d = raw_q;
        dt_d  = dt_q;
        gh_d  = gh_q;
        gl_d  = gl_q;
        for (int i = 0; i < 3; i++) begin
            if (!en) begin
                raw_d[i] = 1'b0;
                dt_d[i]  = 8'd0;
                gh_d[i]  = 1'b0;
                gl_d[i]  = 1'b0;
            end else if (raw[i] != raw_q[i]) begin
                raw_d[i] = raw[i];
                if (DEAD_TIME == 8'd0) begin
                    dt_d[i] = 8'd0;
                    gh_d[i] = raw[i];
                    gl_d[i] = ~raw[i];
                end else begin
                    dt_d[i] = DEAD_TIME;
                    gh_d[i] = 1'b0;
                    gl_d[i] = 1'b0;
                end
            end else if (dt_q[i] > 8'd1) begin
                dt_d[i] = dt_q[i] - 8'd1;
                gh_d[i] = 1'b0;
                gl_d[i] = 1'b0;
            end else begin
                dt_d[i] = 8'd0;
                gh_d[i] = raw_q[i];
                gl_d[i] = ~raw_q[i];
            end
        end
    end

    always_comb begin
        zero_d = en && (cnt_q == 16'd0);
        top_d  = en && (cnt_q == PERIOD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            up_q   <= 1'b1;
            pend_q <= '0;
            act_q  <= '0;
            raw_q  <= '0;
            dt_q   <= '0;
            gh_q   <= '0;
            gl_q   <= '0;
            zero_q <= 1'b0;
            top_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            up_q   <= up_d;
            pend_q <= pend_d;
            act_q  <= act_d;
            raw_q  <= raw_d;
            dt_q   <= dt_d;
            gh_q   <= gh_d;
            gl_q   <= gl_d;
            zero_q <= zero_d;
            top_q  <= top_d;
        end
    end

    assign pwm_ah     = gh_q[0];
    assign pwm_al     = gl_q[0];
    assign pwm_bh     = gh_q[1];
    assign pwm_bl     = gl_q[1];
    assign pwm_ch     = gh_q[2];
    assign pwm_cl     = gl_q[2];
    assign zero_pulse = zero_q;
    assign top_pulse  = top_q;

endmodule

// File: tb/tb_pwm_gen3.sv
// tb/tb_pwm_gen3.sv - scoreboard bench for pwm_gen3 with DEAD_TIME 2 and DEAD_TIME 0 instances
module tb_pwm_gen3;

    localparam logic [15:0] P = 16'd10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        duty_valid = 1'b0;
    logic [15:0] duty_a = '0, duty_b = '0, duty_c = '0;

    logic ah0, al0, bh0, bl0, ch0, cl0, zp0, tp0;
    logic ah1, al1, bh1, bl1, ch1, cl1, zp1, tp1;

    always #5 clk = ~clk;

    pwm_gen3 #(.PERIOD(P), .DEAD_TIME(8'd2)) u_dt2 (
        .rst(rst), .clk(clk), .en(en), .duty_valid(duty_valid),
        .duty_a(duty_a), .duty_b(duty_b), .duty_c(duty_c),
        .pwm_ah(ah0), .pwm_al(al0), .pwm_bh(bh0), .pwm_bl(bl0),
        .pwm_ch(ch0), .pwm_cl(cl0), .zero_pulse(zp0), .top_pulse(tp0)
    );

    pwm_gen3 #(.PERIOD(P), .DEAD_TIME(8'd0)) u_dt0 (
        .rst(rst), .clk(clk), .en(en), .duty_valid(duty_valid),
        .duty_a(duty_a), .duty_b(duty_b), .duty_c(duty_c),
        .pwm_ah(ah1), .pwm_al(al1), .pwm_bh(bh1), .pwm_bl(bl1),
        .pwm_ch(ch1), .pwm_cl(cl1), .zero_pulse(zp1), .top_pulse(tp1)
    );

    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] expq[$];

    // Reference model: phase position in the 2*P period and raw-compare history per phase.
    int          m_p = 0;
    logic [15:0] m_act[3];
    logic [15:0] m_pend[3];
    logic [2:0]  hist[3];

    int g_cnt[2][6];
    int z_cnt, t_cnt, ovl;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] cur_cnt();
        int c;
        c = (m_p <= int'(P)) ? m_p : 2 * int'(P) - m_p;
        return c[15:0];
    endfunction

    function automatic logic [7:0] obs_vec(input int k);
        if (k == 0) return {zp0, tp0, ah0, al0, bh0, bl0, ch0, cl0};
        return {zp1, tp1, ah1, al1, bh1, bl1, ch1, cl1};
    endfunction

    task automatic clear_counts();
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 6; j++) g_cnt[k][j] = 0;
        z_cnt = 0;
        t_cnt = 0;
        ovl   = 0;
    endtask

    task automatic step();
        logic [7:0]  e0, e1, o0, o1, v;
        logic [15:0] e, c;
        logic [2:0]  rw;
        e0 = '0;
        e1 = '0;
        if (rst) begin
            m_p = 0;
            for (int i = 0; i < 3; i++) begin
                m_act[i]  = '0;
                m_pend[i] = '0;
                hist[i]   = '0;
            end
        end else begin
            c = cur_cnt();
            for (int i = 0; i < 3; i++) begin
                rw[i]   = en && (c < m_act[i]);
                hist[i] = {hist[i][1:0], rw[i]};
            end
            e0[7] = en && (c == 16'd0);
            e0[6] = en && (c == P);
            e1[7:6] = e0[7:6];
            for (int i = 0; i < 3; i++) begin
                e0[5-2*i] = en && (hist[i] == 3'b111);
                e0[4-2*i] = en && (hist[i] == 3'b000);
                e1[5-2*i] = en && hist[i][0];
                e1[4-2*i] = en && !hist[i][0];
            end
            if (en && (c == 16'd0)) begin
                for (int i = 0; i < 3; i++) m_act[i] = m_pend[i];
            end
            if (duty_valid) begin
                m_pend[0] = duty_a;
                m_pend[1] = duty_b;
                m_pend[2] = duty_c;
            end
            m_p = en ? (m_p + 1) % (2 * int'(P)) : 0;
        end
        e = {e1, e0};
        expq.push_back(e);
        @(posedge clk);
        #1;
        e  = expq.pop_front();
        o0 = obs_vec(0);
        o1 = obs_vec(1);
        chk("dt2_outputs", o0, e[7:0]);
        chk("dt0_outputs", o1, e[15:8]);
        for (int k = 0; k < 2; k++) begin
            v = (k == 0) ? o0 : o1;
            for (int j = 0; j < 6; j++) g_cnt[k][j] += int'(v[5-j]);
            ovl += int'((v[5] & v[4]) | (v[3] & v[2]) | (v[1] & v[0]));
        end
        z_cnt += int'(o0[7]);
        t_cnt += int'(o0[6]);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic strobe(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        duty_a     = a;
        duty_b     = b;
        duty_c     = c;
        duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
    endtask

    task automatic run_to(input int p);
        for (int g = 0; g < 60 && m_p != p; g++) step();
    endtask

    task automatic chk_window(input string tag, input int k, input int ah, input int al,
                              input int bh, input int bl, input int ch, input int cl);
        chk({tag, "_ah"}, g_cnt[k][0], ah);
        chk({tag, "_al"}, g_cnt[k][1], al);
        chk({tag, "_bh"}, g_cnt[k][2], bh);
        chk({tag, "_bl"}, g_cnt[k][3], bl);
        chk({tag, "_ch"}, g_cnt[k][4], ch);
        chk({tag, "_cl"}, g_cnt[k][5], cl);
    endtask

    initial begin
        clear_counts();
        #1 rst = 1'b1;
        #1;
        chk("reset_dt2", obs_vec(0), 0);
        chk("reset_dt0", obs_vec(1), 0);
        run(2);
        rst = 1'b0;

        // Duty 5 on all phases
        strobe(16'd5, 16'd5, 16'd5);
        en = 1'b1;
        run(40);
        clear_counts();
        run(20);
        chk_window("d5_dt2", 0, 7, 9, 7, 9, 7, 9);
        chk_window("d5_dt0", 1, 9, 11, 9, 11, 9, 11);
        chk("d5_zero_count", z_cnt, 1);
        chk("d5_top_count", t_cnt, 1);
        chk("d5_overlap", ovl, 0);

        // 0%, 100% and minimum duty
        strobe(16'd0, 16'd11, 16'd1);
        run(40);
        clear_counts();
        run(20);
        chk_window("edge_dt2", 0, 0, 20, 20, 0, 0, 17);
        chk_window("edge_dt0", 1, 0, 20, 20, 0, 1, 19);
        chk("edge_overlap", ovl, 0);

        // Mid-period duty change at cnt=6 counting up
        strobe(16'd5, 16'd5, 16'd5);
        run(40);
        run_to(6);
        strobe(16'd8, 16'd8, 16'd8);
        run(30);
        clear_counts();
        run(20);
        chk_window("d8_dt2", 0, 13, 3, 13, 3, 13, 3);
        chk_window("d8_dt0", 1, 15, 5, 15, 5, 15, 5);

        // Duty 3
        strobe(16'd3, 16'd3, 16'd3);
        run(40);
        clear_counts();
        run(20);
        chk_window("d3_dt2", 0, 3, 13, 3, 13, 3, 13);
        chk_window("d3_dt0", 1, 5, 15, 5, 15, 5, 15);

        // Enable dropped at cnt=7, then re-raised
        run_to(7);
        en = 1'b0;
        clear_counts();
        run(6);
        chk("en_low_zero", z_cnt, 0);
        chk("en_low_top", t_cnt, 0);
        chk_window("en_low_dt2", 0, 0, 0, 0, 0, 0, 0);
        en = 1'b1;
        step();
        chk("en_rise_zero_pulse", int'(zp0), 1);
        run(25);

        // Asynchronous reset inside a dead-time gap
        strobe(16'd5, 16'd8, 16'd3);
        run(40);
        run_to(5);
        step();
        #2 rst = 1'b1;
        #1;
        chk("rst_async_dt2", obs_vec(0), 0);
        chk("rst_async_dt0", obs_vec(1), 0);
        step();
        rst = 1'b0;
        step();
        chk("rst_first_zero_pulse", int'(zp0), 1);
        run(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
